zbt_bank_arbiter: RTL
=====================

# zbt_bank_arbiter

Shares one ZBT SRAM bank between two requesters on the shared 65 MHz pixel clock: a write requester (color-reduced pixel pairs from the bank-0 read path) and a read requester (the display fetch). It issues at most one access per cycle and registers address and write-enable onto the bank. It re-times write data to the ZBT two-cycle pipeline and flags returning read data exactly when it is valid. Reads have priority; an optional starvation guard bounds write stall.

## Interface
- MAX_RD_BURST, default 8: consecutive read grants allowed while a write waits (starvation guard only); legal 1–255.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  write request
- wr_addr  in  19  write address {vcount, hcount[9:1]}
- wr_data  in  36  two-pixel write word
- wr_ready  out  1  write accepted this cycle (combinational)
- rd_valid  in  1  read request
- rd_addr  in  19  read address
- rd_ready  out  1  read accepted this cycle (combinational)
- rd_data  out  36  read word, equals zbt_read_data
- rd_data_valid  out  1  rd_data is the word for the read accepted 3 cycles earlier
- zbt_addr  out  19  bank address, registered
- zbt_we  out  1  bank write enable, registered, active-high
- zbt_write_data  out  36  bank write data, registered
- zbt_read_data  in  36  bank read data

## Operation
- Handshake: a transfer occurs on a cycle where valid && ready. Requesters hold addr/data stable while valid && !ready.
- Arbitration per cycle:
  - rd_ready = rd_valid && !force_wr.
  - wr_ready = wr_valid && (!rd_valid || force_wr).
  - Never both high.
- Idle cycle (no grant): zbt_we <= 0, and zbt_addr holds its previous value.
- Starvation counter (8 bits), active only with ZBT_ARB_STARVE_EN:
  - Increments on each read grant while wr_valid = 1.
  - Clears on a write grant or whenever wr_valid = 0.
  - force_wr = (count == MAX_RD_BURST).
- Write path: grant at cycle t loads addr/we=1 at t+1. wr_data enters a 2-stage delay and drives zbt_write_data at t+3, matching the ZBT data-after-address pipeline.
- Read path: grant at cycle t loads addr/we=0 at t+1. A 2-deep read-tag shift pipeline asserts rd_data_valid at t+3, when zbt_read_data carries the word.
- Back-to-back mixed grants (R,W,R,W…) are legal every cycle; ZBT needs no turnaround.
- Reset values:
  - zbt_addr = 0, zbt_we = 0, zbt_write_data = 0.
  - rd_data_valid = 0, starvation counter = 0.
  - All delay/tag stages cleared.
- Reset mid-operation: in-flight reads are dropped (no rd_data_valid afterwards); in-flight write data is discarded; a write whose zbt_we was already issued is not recalled.

## Timing
- Grant decision: combinational, same cycle as request.
- Address/WE latency: 1 cycle after grant.
- Write data latency: 3 cycles after grant (2 after address).
- Read data latency: 3 cycles after grant (2 after address); rd_data_valid is a 1-cycle pulse per read.
- Throughput: one access per cycle, sustained.
- Worst-case write wait with guard: MAX_RD_BURST cycles. Without guard: unbounded while rd_valid is held.

## Configuration
- ZBT_ARB_STARVE_EN defined: starvation counter and force_wr are compiled in as described.
- Undefined: counter absent, force_wr = 0, and pure read priority applies: wr_ready = wr_valid && !rd_valid.

## Test plan
- Single write: wr_addr=0x12345, wr_data=0xABCDEF012, idle otherwise.
  - -> wr_ready high at t; zbt_addr=0x12345 with zbt_we=1 at t+1; zbt_write_data=0xABCDEF012 at t+3.
- Single read: rd_addr=0x00100, bench ZBT model returns 0x5A5A5A5A5 two cycles after address.
  - -> rd_data_valid pulses once at t+3 with rd_data=0x5A5A5A5A5.
- Contention, guard enabled, MAX_RD_BURST=8, rd_valid and wr_valid held high for 20 cycles.
  - -> 8 read grants then 1 write grant, repeating; counter returns to 0 after each write.
- Contention, guard disabled, same stimulus.
  - -> 20 read grants, wr_ready never high.
- Alternating R/W every cycle with distinct addresses.
  - -> zbt_we toggles 0/1 each cycle; each write's data appears 2 cycles after its address.
  - -> rd_data_valid asserted only for read slots.
- Reset asserted 1 cycle after a read grant.
  - -> all outputs 0 next cycle; no rd_data_valid pulse for that read.

Source files
------------

// File: rtl/zbt_bank_arbiter.sv
// ---------------------------------------------------------------------------
// zbt_bank_arbiter
//
// Shares one ZBT SRAM bank between a write requester (color-reduced pixel
// pairs) and a read requester (display fetch). At most one access is issued
// per cycle. Address and write enable are registered onto the bank. Write
// data is re-timed to the ZBT data-after-address pipeline. Returning read
// data is flagged on the cycle it is valid.
//
// Reads have priority. When ZBT_ARB_STARVE_EN is defined, a starvation
// counter forces a write grant after MAX_RD_BURST consecutive read grants
// while a write is waiting. When it is undefined, pure read priority applies.
//
// Parameters
//   MAX_RD_BURST    read grants allowed while a write waits (1..255);
//                   used only with ZBT_ARB_STARVE_EN
//
// Ports
//   clk             system (pixel) clock
//   reset           synchronous, active-high reset
//   wr_valid        write request
//   wr_addr[18:0]   write address
//   wr_data[35:0]   two-pixel write word
//   wr_ready        write accepted this cycle (combinational)
//   rd_valid        read request
//   rd_addr[18:0]   read address
//   rd_ready        read accepted this cycle (combinational)
//   rd_data[35:0]   read word, straight from zbt_read_data
//   rd_data_valid   rd_data is the word for the read accepted 3 cycles ago
//   zbt_addr[18:0]  bank address, registered
//   zbt_we          bank write enable, registered, active-high
//   zbt_write_data  bank write data, registered, 2 cycles after its address
//   zbt_read_data   bank read data, 2 cycles after its address
// ---------------------------------------------------------------------------
module zbt_bank_arbiter #(
    parameter int MAX_RD_BURST = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        wr_valid,
    input  logic [18:0] wr_addr,
    input  logic [35:0] wr_data,
    output logic        wr_ready,

    input  logic        rd_valid,
    input  logic [18:0] rd_addr,
    output logic        rd_ready,
    output logic [35:0] rd_data,
    output logic        rd_data_valid,

    output logic [18:0] zbt_addr,
    output logic        zbt_we,
    output logic [35:0] zbt_write_data,
    input  logic [35:0] zbt_read_data
);

    logic rd_grant;
    logic wr_grant;
    logic force_wr;

    // ------------------------------------------------------------------
    // Arbitration: reads win unless the starvation guard forces a write.
    // The two grants are mutually exclusive by construction.
    // ------------------------------------------------------------------
    assign rd_ready = rd_valid && !force_wr;
    assign wr_ready = wr_valid && (!rd_valid || force_wr);

    assign rd_grant = rd_ready;
    assign wr_grant = wr_ready;

`ifdef ZBT_ARB_STARVE_EN
    localparam logic [7:0] MAX_CNT = 8'(MAX_RD_BURST);

    logic [7:0] starve_cnt;

    // Counts read grants taken while a write is waiting. It can never pass
    // MAX_CNT: at MAX_CNT the pending write is forced, which clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 8'd0;
        end else if (!wr_valid || wr_grant) begin
            starve_cnt <= 8'd0;
        end else if (rd_grant) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    assign force_wr = (starve_cnt == MAX_CNT);
`else
    logic [31:0] unused_max_rd_burst;

    assign unused_max_rd_burst = 32'(MAX_RD_BURST);
    assign force_wr            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bank address / write enable, one cycle after the grant. On an idle
    // cycle the address is left where it was and WE drops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            zbt_addr <= 19'd0;
            zbt_we   <= 1'b0;
        end else begin
            zbt_we <= wr_grant;
            if (rd_grant) begin
                zbt_addr <= rd_addr;
            end else if (wr_grant) begin
                zbt_addr <= wr_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write data re-timing: grant at t -> stage 1 at t+1 -> stage 2 at t+2
    // -> bank data at t+3, i.e. two cycles behind its address. Stage 1 only
    // loads on a write grant, so a write's word still lines up when other
    // slots (reads, idles) sit between writes.
    // ------------------------------------------------------------------
    logic [35:0] wr_data_s1;
    logic [35:0] wr_data_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_data_s1     <= 36'd0;
            wr_data_s2     <= 36'd0;
            zbt_write_data <= 36'd0;
        end else begin
            if (wr_grant) begin
                wr_data_s1 <= wr_data;
            end
            wr_data_s2     <= wr_data_s1;
            zbt_write_data <= wr_data_s2;
        end
    end

    // ------------------------------------------------------------------
    // Read tag pipeline: one tag per read grant, two stages deep, then the
    // registered valid flag lands on t+3 alongside the bank's read data.
    // Reset clears every stage, so in-flight reads never report.
    // ------------------------------------------------------------------
    logic [1:0] rd_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag        <= 2'b00;
            rd_data_valid <= 1'b0;
        end else begin
            rd_tag        <= {rd_tag[0], rd_grant};
            rd_data_valid <= rd_tag[1];
        end
    end

    assign rd_data = zbt_read_data;

endmodule
